// File: rtl/spi_slave_if.sv
// SPI slave front end for the single-port RAM: deserialises 10-bit command words
// from MOSI and serialises 8-bit read data back on MISO. SCK is the system clock.
module spi_slave_if #(
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 SS_n,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic [ADDR_SIZE+1:0] rx_data,
  output logic                 rx_valid,
  input  logic [ADDR_SIZE-1:0] tx_data,
  input  logic                 tx_valid,
  output logic [2:0]           state_o,
  output logic                 rd_addr_seen_o
);

  localparam int W  = ADDR_SIZE + 2;
  localparam int CW = $clog2(W);
  localparam int TW = $clog2(ADDR_SIZE);

  localparam logic [CW-1:0] BIT_LAST = CW'(W - 2);
  localparam logic [CW-1:0] BIT_DONE = CW'(W - 1);
  localparam logic [TW-1:0] TX_LAST  = TW'(ADDR_SIZE - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [CW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [W-1:0]           rx_sh_q, rx_sh_d;
  logic [W-1:0]           rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   rd_addr_seen_q, rd_addr_seen_d;
  logic [ADDR_SIZE-1:0]   tx_sh_q, tx_sh_d;
  logic [TW-1:0]          tx_cnt_q, tx_cnt_d;
  logic                   tx_busy_q, tx_busy_d;
  logic                   tx_done_q, tx_done_d;
  logic                   miso_q, miso_d;

  // Handshake: rx_valid is a single-cycle strobe with rx_data stable from that
  // cycle until the next complete word; tx_valid is level-sampled once per
  // read-data frame and only after that frame's word has been delivered.
  always_comb begin
    state_d        = state_q;
    bit_cnt_d      = bit_cnt_q;
    rx_sh_d        = rx_sh_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    rd_addr_seen_d = rd_addr_seen_q;
    tx_sh_d        = tx_sh_q;
    tx_cnt_d       = tx_cnt_q;
    tx_busy_d      = tx_busy_q;
    tx_done_d      = tx_done_q;
    miso_d         = miso_q;

    if (state_q == IDLE) begin
      miso_d    = 1'b0;
      bit_cnt_d = '0;
      tx_cnt_d  = '0;
      tx_busy_d = 1'b0;
      tx_done_d = 1'b0;
      if (!SS_n) state_d = CHK_CMD;
    end else if (SS_n) begin
      // Frame aborted or finished: drop everything in flight, keep rx_data and
      // rd_addr_seen so a half-sent frame has no architectural effect.
      state_d   = IDLE;
      miso_d    = 1'b0;
      bit_cnt_d = '0;
      tx_cnt_d  = '0;
      tx_sh_d   = '0;
      tx_busy_d = 1'b0;
      tx_done_d = 1'b0;
    end else begin
      case (state_q)
        CHK_CMD: begin
          rx_sh_d   = {{(W-1){1'b0}}, MOSI};
          bit_cnt_d = '0;
          if (!MOSI)               state_d = WRITE;
          else if (rd_addr_seen_q) state_d = READ_DATA;
          else                     state_d = READ_ADD;
        end
        default: begin
          if (bit_cnt_q != BIT_DONE) begin
            rx_sh_d   = {rx_sh_q[W-2:0], MOSI};
            bit_cnt_d = bit_cnt_q + CW'(1);
            if (bit_cnt_q == BIT_LAST) begin
              rx_data_d  = {rx_sh_q[W-2:0], MOSI};
              rx_valid_d = 1'b1;
              if (state_q == READ_ADD) rd_addr_seen_d = 1'b1;
            end
          end else if (state_q == READ_DATA) begin
            if (tx_busy_q) begin
              if (tx_cnt_q == TX_LAST) begin
                miso_d         = 1'b0;
                tx_busy_d      = 1'b0;
                tx_done_d      = 1'b1;
                rd_addr_seen_d = 1'b0;
              end else begin
                miso_d   = tx_sh_q[ADDR_SIZE-1];
                tx_sh_d  = {tx_sh_q[ADDR_SIZE-2:0], 1'b0};
                tx_cnt_d = tx_cnt_q + TW'(1);
              end
            end else if (!tx_done_q && tx_valid) begin
              miso_d    = tx_data[ADDR_SIZE-1];
              tx_sh_d   = {tx_data[ADDR_SIZE-2:0], 1'b0};
              tx_cnt_d  = '0;
              tx_busy_d = 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      bit_cnt_q      <= '0;
      rx_sh_q        <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      rd_addr_seen_q <= 1'b0;
      tx_sh_q        <= '0;
      tx_cnt_q       <= '0;
      tx_busy_q      <= 1'b0;
      tx_done_q      <= 1'b0;
      miso_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      rx_sh_q        <= rx_sh_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      rd_addr_seen_q <= rd_addr_seen_d;
      tx_sh_q        <= tx_sh_d;
      tx_cnt_q       <= tx_cnt_d;
      tx_busy_q      <= tx_busy_d;
      tx_done_q      <= tx_done_d;
      miso_q         <= miso_d;
    end
  end

  assign MISO           = miso_q;
  assign rx_data        = rx_data_q;
  assign rx_valid       = rx_valid_q;
  assign state_o        = state_q;
  assign rd_addr_seen_o = rd_addr_seen_q;

endmodule

// File: tb/tb_spi_slave_if.sv
// Directed bench for spi_slave_if: inputs driven and outputs sampled on the
// falling edge; the DUT samples on the rising edge.
module tb_spi_slave_if;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_READ_ADD  = 3'd3;
  localparam logic [2:0] S_READ_DATA = 3'd4;

  logic       clk = 1'b0;
  logic       rst;
  logic       ss_n;
  logic       mosi;
  logic       miso;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic [2:0] state_o;
  logic       rd_addr_seen_o;

  int errors = 0;
  int checks = 0;
  int rxv_cnt = 0;
  int miso_ones = 0;
  int consec = 0;
  logic prev_rxv = 1'b0;

  spi_slave_if #(.ADDR_SIZE(8)) dut (
    .clk(clk), .rst(rst), .SS_n(ss_n), .MOSI(mosi), .MISO(miso),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data),
    .tx_valid(tx_valid), .state_o(state_o), .rd_addr_seen_o(rd_addr_seen_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) rxv_cnt++;
    if (rx_valid && prev_rxv) consec++;
    if (miso === 1'b1) miso_ones++;
    prev_rxv = rx_valid;
  end

  // Driver: SS_n low, then the first n bits of w MSB-first, one per cycle.
  task automatic drive_frame_bits(input logic [9:0] w, input int n);
    @(negedge clk); ss_n = 1'b0; mosi = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk); mosi = w[9-i];
    end
  endtask

  task automatic end_frame();
    @(negedge clk); ss_n = 1'b1; mosi = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; ss_n = 1'b1; mosi = 1'b0; tx_data = 8'h00; tx_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b want 0", miso); end
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
    checks++; if (rx_data !== 10'h000) begin errors++; $display("FAIL reset_rx_data: got %h want 000", rx_data); end
    checks++; if (state_o !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d want 0", state_o); end
    checks++; if (rd_addr_seen_o !== 1'b0) begin errors++; $display("FAIL reset_rd_addr_seen: got %b want 0", rd_addr_seen_o); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_addr();
    rxv_cnt = 0; miso_ones = 0;
    drive_frame_bits(10'h0A5, 10);
    @(negedge clk);
    checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL wr_addr_valid: got %b want 1", rx_valid); end
    checks++; if (rx_data !== 10'h0A5) begin errors++; $display("FAIL wr_addr_data: got %h want 0a5", rx_data); end
    @(negedge clk);
    checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL wr_addr_strobe_len: got %b want 0", rx_valid); end
    end_frame();
    checks++; if (rxv_cnt !== 1) begin errors++; $display("FAIL wr_addr_pulses: got %0d want 1", rxv_cnt); end
    checks++; if (miso_ones !== 0) begin errors++; $display("FAIL wr_addr_miso: got %0d ones want 0", miso_ones); end
    checks++; if (state_o !== S_IDLE) begin errors++; $display("FAIL wr_addr_idle: got %0d want 0", state_o); end
  endtask

  task automatic test_write_data();
    rxv_cnt = 0;
    drive_frame_bits(10'h13C, 10);
    @(negedge clk);
    checks++; if (rx_data !== 10'h13C || rx_valid !== 1'b1) begin errors++; $display("FAIL wr_data: got %h/%b want 13c/1", rx_data, rx_valid); end
    end_frame();
    checks++; if (rxv_cnt !== 1) begin errors++; $display("FAIL wr_data_pulses: got %0d want 1", rxv_cnt); end
    checks++; if (rd_addr_seen_o !== 1'b0) begin errors++; $display("FAIL wr_data_rd_seen: got %b want 0", rd_addr_seen_o); end
  endtask

  task automatic test_read_seq();
    logic [7:0] exp_byte;
    exp_byte = 8'hC3;
    drive_frame_bits(10'h2A5, 10);
    @(negedge clk);
    checks++; if (rx_data !== 10'h2A5 || rx_valid !== 1'b1) begin errors++; $display("FAIL rd_addr: got %h/%b want 2a5/1", rx_data, rx_valid); end
    checks++; if (state_o !== S_READ_ADD) begin errors++; $display("FAIL rd_addr_state: got %0d want 3", state_o); end
    end_frame();
    checks++; if (rd_addr_seen_o !== 1'b1) begin errors++; $display("FAIL rd_addr_seen_set: got %b want 1", rd_addr_seen_o); end
    miso_ones = 0;
    drive_frame_bits(10'h300, 10);
    @(negedge clk);
    checks++; if (rx_data !== 10'h300 || rx_valid !== 1'b1) begin errors++; $display("FAIL rd_data_word: got %h/%b want 300/1", rx_data, rx_valid); end
    checks++; if (state_o !== S_READ_DATA) begin errors++; $display("FAIL rd_data_state: got %0d want 4", state_o); end
    @(negedge clk);
    checks++; if (miso !== 1'b0) begin errors++; $display("FAIL rd_data_pre_miso: got %b want 0", miso); end
    tx_valid = 1'b1; tx_data = 8'hC3;
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk);
      checks++; if (miso !== exp_byte[i]) begin errors++; $display("FAIL rd_data_bit%0d: got %b want %b", i, miso, exp_byte[i]); end
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (miso !== 1'b0) begin errors++; $display("FAIL rd_data_tail%0d: got %b want 0", i, miso); end
    end
    checks++; if (miso_ones !== 4) begin errors++; $display("FAIL rd_data_once: got %0d ones want 4", miso_ones); end
    checks++; if (rd_addr_seen_o !== 1'b0) begin errors++; $display("FAIL rd_data_seen_clr: got %b want 0", rd_addr_seen_o); end
    tx_valid = 1'b0;
    end_frame();
  endtask

  task automatic test_abort();
    rxv_cnt = 0;
    drive_frame_bits(10'h0FF, 6);
    @(negedge clk); ss_n = 1'b1;
    @(negedge clk);
    checks++; if (state_o !== S_IDLE) begin errors++; $display("FAIL abort_state: got %0d want 0", state_o); end
    checks++; if (rx_data !== 10'h300) begin errors++; $display("FAIL abort_rx_data: got %h want 300", rx_data); end
    checks++; if (rxv_cnt !== 0) begin errors++; $display("FAIL abort_pulses: got %0d want 0", rxv_cnt); end
    @(negedge clk);
  endtask

  task automatic test_read_abort();
    logic [7:0] exp_byte;
    exp_byte = 8'hA5;
    drive_frame_bits(10'h255, 10);
    end_frame();
    drive_frame_bits(10'h3FF, 10);
    @(negedge clk);
    @(negedge clk); tx_valid = 1'b1; tx_data = 8'hA5;
    for (int i = 7; i >= 5; i--) begin
      @(negedge clk);
      checks++; if (miso !== exp_byte[i]) begin errors++; $display("FAIL rd_abort_bit%0d: got %b want %b", i, miso, exp_byte[i]); end
    end
    ss_n = 1'b1; tx_valid = 1'b0;
    @(negedge clk);
    checks++; if (miso !== 1'b0 || state_o !== S_IDLE) begin errors++; $display("FAIL rd_abort_stop: got miso=%b state=%0d want 0/0", miso, state_o); end
    checks++; if (rd_addr_seen_o !== 1'b1) begin errors++; $display("FAIL rd_abort_seen: got %b want 1", rd_addr_seen_o); end
    drive_frame_bits(10'h300, 10);
    @(negedge clk);
    checks++; if (state_o !== S_READ_DATA) begin errors++; $display("FAIL rd_abort_next: got %0d want 4", state_o); end
    end_frame();
  endtask

  task automatic test_reset_mid_frame();
    drive_frame_bits(10'h0A5, 5);
    @(negedge clk);
    #2 rst = 1'b1; ss_n = 1'b1;
    #1;
    checks++; if (miso !== 1'b0 || rx_valid !== 1'b0 || rx_data !== 10'h000) begin errors++; $display("FAIL midrst_outputs: got %b/%b/%h want 0/0/000", miso, rx_valid, rx_data); end
    checks++; if (state_o !== S_IDLE || rd_addr_seen_o !== 1'b0) begin errors++; $display("FAIL midrst_state: got %0d/%b want 0/0", state_o, rd_addr_seen_o); end
    @(negedge clk); rst = 1'b0;
    drive_frame_bits(10'h13C, 10);
    @(negedge clk);
    checks++; if (rx_data !== 10'h13C || rx_valid !== 1'b1) begin errors++; $display("FAIL midrst_next: got %h/%b want 13c/1", rx_data, rx_valid); end
    end_frame();
  endtask

  task automatic test_back_to_back();
    rxv_cnt = 0;
    drive_frame_bits(10'h0A5, 10);
    @(negedge clk);
    checks++; if (rx_data !== 10'h0A5) begin errors++; $display("FAIL b2b_first: got %h want 0a5", rx_data); end
    @(negedge clk); ss_n = 1'b1;
    drive_frame_bits(10'h1C3, 10);
    @(negedge clk);
    checks++; if (rx_data !== 10'h1C3 || rx_valid !== 1'b1) begin errors++; $display("FAIL b2b_second: got %h/%b want 1c3/1", rx_data, rx_valid); end
    end_frame();
    checks++; if (rxv_cnt !== 2) begin errors++; $display("FAIL b2b_pulses: got %0d want 2", rxv_cnt); end
    checks++; if (consec !== 0) begin errors++; $display("FAIL rx_valid_consecutive: got %0d want 0", consec); end
  endtask

  initial begin
    test_reset();
    test_write_addr();
    test_write_data();
    test_read_seq();
    test_abort();
    test_read_abort();
    test_reset_mid_frame();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
